soundweb_tx_framer: RTL and testbench
=====================================

# soundweb_tx_framer

Serialises one unescaped Soundweb message (command, 6 address bytes, 2 SV bytes, 4 data bytes) into the on-wire byte stream. The stream is STX, the escaped body, the escaped XOR checksum, then ETX. Sits directly downstream of the parallel packet builder and upstream of the UART transmitter. It presents one byte at a time on a valid/ready interface and absorbs UART backpressure.

## Interface
- `IDLE_GAP`, default 0: minimum idle cycles after the ETX handshake before `msg_ready` reasserts (0–255).
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `msg_valid` in 1: message fields are valid.
- `msg_ready` out 1: framer can accept a message; high only in IDLE.
- `command` in 8: command byte.
- `address_0`..`address_5` in 8 each: node/VD/object address bytes, sent in order 0→5.
- `sv_0`, `sv_1` in 8 each: state-variable ID.
- `data_0`..`data_3` in 8 each: value, `data_0` first.
- `tx_data` out 8: wire byte to the UART.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: UART accepts the byte on this edge.
- `busy` out 1: high from message capture until the ETX handshake completes.
- `frame_count` out 16: completed frames. Present only with the macro in Configuration.

## Operation
- Reserved bytes: 0x02 STX, 0x03 ETX, 0x06 ACK, 0x15 NAK, 0x1B ESC.
  - A reserved byte b is emitted as 0x1B followed by (b + 0x80) mod 256.
  - Non-reserved bytes are emitted unchanged.
- Capture:
  - Occurs when `msg_valid && msg_ready`. All 13 fields are registered into a body array indexed 0 (command) to 12 (`data_3`).
  - Checksum is the XOR of the 13 unescaped body bytes, registered at capture.
  - Inputs are ignored after capture.
- States and transitions:
  - IDLE → STX on capture.
  - STX → BODY.
  - BODY → BODY_ESC when the current byte is reserved, after ESC is accepted.
  - BODY_ESC → BODY, or → CSUM after index 12.
  - BODY → CSUM after index 12 is accepted.
  - CSUM → CSUM_ESC when the checksum is reserved.
  - CSUM / CSUM_ESC → ETX.
  - ETX → GAP when `IDLE_GAP` > 0, else → IDLE.
  - GAP → IDLE after `IDLE_GAP` cycles.
- Any state advance happens only on a `tx_valid && tx_ready` handshake.
- Body index: 4-bit counter, 0→12. It increments on acceptance of a non-escaped byte or of the second byte of an escape pair. It never wraps mid-frame.
- Frame length: 16 bytes minimum (no reserved bytes), 30 bytes maximum (all 14 body/checksum bytes escaped).
- Reset values: state IDLE, `tx_valid` 0, `tx_data` 0x00, `busy` 0, `frame_count` 0, body and checksum 0.
  - `msg_ready` is 0 while `rst` is high and 1 the cycle after.

## Timing
- `tx_data` and `tx_valid` are registered and do not depend combinationally on `tx_ready`.
- While `tx_valid && !tx_ready`, `tx_data` holds stable.
- Latency: capture on edge N; STX is valid after edge N (`tx_valid` high in cycle N+1).
- With `tx_ready` held high, one byte is emitted per cycle and the frame occupies exactly its byte count in cycles.
- `msg_ready` reasserts in the cycle after the ETX handshake plus `IDLE_GAP` cycles.
  - With `IDLE_GAP` = 0, back-to-back frames are separated by one idle cycle.
- `rst` mid-frame:
  - The frame is abandoned; no ETX is sent and `frame_count` does not increment.
  - `tx_valid` is 0 after the reset edge.
- `msg_valid` during a frame is ignored; the source holds its message until `msg_ready`.

## Configuration
- `SOUNDWEB_TX_FRAME_COUNT_EN` defined:
  - `frame_count` port exists. It increments by 1 on each ETX handshake and wraps 0xFFFF→0x0000.
  - It is cleared only by `rst`.
- `SOUNDWEB_TX_FRAME_COUNT_EN` undefined: the port and counter are absent. Framing behaviour is identical.

## Structure
- Shared package `soundweb_pkg` holds:
  - Constants STX, ETX, ACK, NAK, ESC, ESC_OFFSET (0x80) and BODY_LEN (13).
  - The state encoding.
  - The `is_reserved_byte` function, shared with the receive side.
- Sub-module `soundweb_escape` (combinational):
  - Input: byte `b`.
  - Outputs: `is_reserved`, `escaped` (b + 0x80).
  - Instantiated for the body byte mux and reused for the checksum.

## Test plan
- Plain frame:
  - Stimulus: command 0x88, address 10 20 30 40 50 60, sv 00 01, data 00 00 00 64, `tx_ready` = 1.
  - Expected: 02 88 10 20 30 40 50 60 00 01 00 00 00 64 9D 03 in 16 consecutive cycles.
- Escaped data: same as the plain frame but `data_3` = 0x03 → …00 00 00 1B 83 FA 03, 17 bytes.
- Escaped checksum: same as the plain frame but `data_3` = 0xFB → checksum 0x02, emitted as 1B 82 then 03.
- Backpressure:
  - Stimulus: plain frame with `tx_ready` alternating 1/0.
  - Expected: identical byte sequence; `tx_data` stable in every stalled cycle; frame takes 31 or 32 cycles.
- Reset mid-frame:
  - Stimulus: assert `rst` for 1 cycle after the 5th byte handshake.
  - Expected: `tx_valid` is 0 the next cycle, no ETX is sent, `frame_count` is unchanged. The next message starts with 02.
- Gap and count:
  - Stimulus: `IDLE_GAP` = 4, two back-to-back plain frames.
  - Expected: `msg_ready` low for 4 cycles after the first ETX. `frame_count` reads 2 after the second ETX.

Source files
------------

// File: rtl/soundweb_pkg.sv
// Shared Soundweb framing constants, framer state encoding and reserved-byte test.
// Used by both the transmit framer and the receive side.
package soundweb_pkg;

  localparam logic [7:0] STX        = 8'h02;
  localparam logic [7:0] ETX        = 8'h03;
  localparam logic [7:0] ACK        = 8'h06;
  localparam logic [7:0] NAK        = 8'h15;
  localparam logic [7:0] ESC        = 8'h1B;
  localparam logic [7:0] ESC_OFFSET = 8'h80;
  localparam int         BODY_LEN   = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STX,
    S_BODY,
    S_BODY_ESC,
    S_CSUM,
    S_CSUM_ESC,
    S_ETX,
    S_GAP
  } tx_state_e;

  function automatic logic is_reserved_byte(input logic [7:0] b);
    return (b == STX) || (b == ETX) || (b == ACK) || (b == NAK) || (b == ESC);
  endfunction

endpackage

// File: rtl/soundweb_escape.sv
// Combinational escape helper: flags a reserved byte and forms its escaped second byte.
module soundweb_escape
  import soundweb_pkg::*;
(
  input  logic [7:0] b,
  output logic       is_reserved,
  output logic [7:0] escaped
);

  assign is_reserved = is_reserved_byte(b);
  assign escaped     = b + ESC_OFFSET;

endmodule

// File: rtl/soundweb_tx_framer.sv
// Soundweb transmit framer: STX, escaped body, escaped XOR checksum, ETX, one byte per handshake.
// Optional completed-frame counter port enabled by defining SOUNDWEB_TX_FRAME_COUNT_EN.
module soundweb_tx_framer
  import soundweb_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [7:0]  command,
  input  logic [7:0]  address_0,
  input  logic [7:0]  address_1,
  input  logic [7:0]  address_2,
  input  logic [7:0]  address_3,
  input  logic [7:0]  address_4,
  input  logic [7:0]  address_5,
  input  logic [7:0]  sv_0,
  input  logic [7:0]  sv_1,
  input  logic [7:0]  data_0,
  input  logic [7:0]  data_1,
  input  logic [7:0]  data_2,
  input  logic [7:0]  data_3,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
`ifdef SOUNDWEB_TX_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(BODY_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

  tx_state_e                state, state_d;
  logic [BODY_LEN-1:0][7:0] body, msg_body;
  logic [7:0]               csum, msg_csum;
  logic [3:0]               idx, idx_d;
  logic [7:0]               gap_cnt, gap_cnt_d;
  logic                     capture, hs;
  logic [7:0]               tx_data_d;
  logic                     tx_valid_d;
  logic [7:0]               esc_in, esc_out;
  logic                     esc_res;

  assign msg_body = {data_3, data_2, data_1, data_0, sv_1, sv_0,
                     address_5, address_4, address_3, address_2, address_1, address_0,
                     command};

  always_comb begin
    msg_csum = 8'h00;
    for (int i = 0; i < BODY_LEN; i++) msg_csum = msg_csum ^ msg_body[i];
  end

  assign hs        = tx_valid && tx_ready;
  assign msg_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE) && (state != S_GAP);

  // In BODY/CSUM the presented byte is ESC exactly when the source byte is reserved,
  // since an unescaped 0x1B can never appear on the wire.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    gap_cnt_d = gap_cnt;
    capture   = 1'b0;
    unique case (state)
      S_IDLE: if (msg_valid) begin
        capture = 1'b1;
        state_d = S_STX;
      end
      S_STX: if (hs) begin
        state_d = S_BODY;
        idx_d   = 4'd0;
      end
      S_BODY: if (hs) begin
        if (tx_data == ESC)       state_d = S_BODY_ESC;
        else if (idx == LAST_IDX) state_d = S_CSUM;
        else                      idx_d   = idx + 4'd1;
      end
      S_BODY_ESC: if (hs) begin
        if (idx == LAST_IDX) state_d = S_CSUM;
        else begin
          state_d = S_BODY;
          idx_d   = idx + 4'd1;
        end
      end
      S_CSUM: if (hs) state_d = (tx_data == ESC) ? S_CSUM_ESC : S_ETX;
      S_CSUM_ESC: if (hs) state_d = S_ETX;
      S_ETX: if (hs) begin
        gap_cnt_d = 8'd0;
        state_d   = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d   = S_IDLE;
        else                     gap_cnt_d = gap_cnt + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The byte for the next state is formed ahead of time so tx_data is a plain register;
  // an unchanged state recomputes the same byte, which keeps tx_data stable under stall.
  assign esc_in = ((state_d == S_CSUM) || (state_d == S_CSUM_ESC)) ? csum : body[idx_d];

  soundweb_escape u_escape (
    .b           (esc_in),
    .is_reserved (esc_res),
    .escaped     (esc_out)
  );

  always_comb begin
    tx_data_d  = 8'h00;
    tx_valid_d = 1'b1;
    unique case (state_d)
      S_STX:                  tx_data_d = STX;
      S_BODY, S_CSUM:         tx_data_d = esc_res ? ESC : esc_in;
      S_BODY_ESC, S_CSUM_ESC: tx_data_d = esc_out;
      S_ETX:                  tx_data_d = ETX;
      default:                tx_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= 4'd0;
      gap_cnt  <= 8'd0;
      body     <= '0;
      csum     <= 8'h00;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      gap_cnt  <= gap_cnt_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
      if (capture) begin
        body <= msg_body;
        csum <= msg_csum;
      end
    end
  end

`ifdef SOUNDWEB_TX_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                        frame_count <= 16'h0000;
    else if (hs && state == S_ETX)  frame_count <= frame_count + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_soundweb_tx_framer.sv
// Directed bench for soundweb_tx_framer: two instances (IDLE_GAP 0 and 4) sharing the message bus.
module tb_soundweb_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       msg_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic       sel = 1'b0;
  logic [7:0] f [13];

  logic       mv_0, mv_g, mr_0, mr_g, tv_0, tv_g, bz_0, bz_g;
  logic [7:0] td_0, td_g;
  logic       mr, tv, bz;
  logic [7:0] td;
`ifdef SOUNDWEB_TX_FRAME_COUNT_EN
  logic [15:0] fc_0, fc_g, fc;
  assign fc = sel ? fc_g : fc_0;
`endif

  always #5 clk = ~clk;

  assign mv_0 = msg_valid && !sel;
  assign mv_g = msg_valid && sel;
  assign mr   = sel ? mr_g : mr_0;
  assign tv   = sel ? tv_g : tv_0;
  assign td   = sel ? td_g : td_0;
  assign bz   = sel ? bz_g : bz_0;

  soundweb_tx_framer #(.IDLE_GAP(0)) dut (
    .clk(clk), .rst(rst), .msg_valid(mv_0), .msg_ready(mr_0),
    .command(f[0]), .address_0(f[1]), .address_1(f[2]), .address_2(f[3]),
    .address_3(f[4]), .address_4(f[5]), .address_5(f[6]), .sv_0(f[7]), .sv_1(f[8]),
    .data_0(f[9]), .data_1(f[10]), .data_2(f[11]), .data_3(f[12]),
    .tx_data(td_0), .tx_valid(tv_0), .tx_ready(tx_ready), .busy(bz_0)
`ifdef SOUNDWEB_TX_FRAME_COUNT_EN
    , .frame_count(fc_0)
`endif
  );

  soundweb_tx_framer #(.IDLE_GAP(4)) dut_g (
    .clk(clk), .rst(rst), .msg_valid(mv_g), .msg_ready(mr_g),
    .command(f[0]), .address_0(f[1]), .address_1(f[2]), .address_2(f[3]),
    .address_3(f[4]), .address_4(f[5]), .address_5(f[6]), .sv_0(f[7]), .sv_1(f[8]),
    .data_0(f[9]), .data_1(f[10]), .data_2(f[11]), .data_3(f[12]),
    .tx_data(td_g), .tx_valid(tv_g), .tx_ready(tx_ready), .busy(bz_g)
`ifdef SOUNDWEB_TX_FRAME_COUNT_EN
    , .frame_count(fc_g)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic set_msg(input logic [7:0] d3);
    f[0] = 8'h88; f[1] = 8'h10; f[2] = 8'h20; f[3] = 8'h30; f[4] = 8'h40;
    f[5] = 8'h50; f[6] = 8'h60; f[7] = 8'h00; f[8] = 8'h01;
    f[9] = 8'h00; f[10] = 8'h00; f[11] = 8'h00; f[12] = d3;
  endtask

  // Called on a negedge; returns on the negedge after the capture edge.
  task automatic send();
    int n = 0;
    msg_valid = 1'b1;
    while (!mr && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("msg_ready", mr, 1);
    @(posedge clk);
    @(negedge clk);
    msg_valid = 1'b0;
    chk("stx_latency", tv, 1);
    chk("busy_in_frame", bz, 1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] want[$], input bit alt);
    logic [7:0] got[$];
    int         cyc = 0;
    bit         held = 1'b0;
    logic [7:0] hv = 8'h00;
    send();
    while (got.size() < want.size() && cyc < 200) begin
      tx_ready = alt ? (cyc % 2 == 0) : 1'b1;
      if (held) chk({tag, "_stall_hold"}, td, hv);
      held = 1'b0;
      if (tv) begin
        if (tx_ready) got.push_back(td);
        else begin
          held = 1'b1;
          hv   = td;
        end
      end
      cyc++;
      @(negedge clk);
    end
    tx_ready = 1'b1;
    chk({tag, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(want[i]));
    if (alt) chk({tag, "_cycles_31_32"}, 32'((cyc == 31) || (cyc == 32)), 1);
    else     chk({tag, "_cycles"}, cyc, want.size());
    chk({tag, "_tv_after"}, tv, 0);
    chk({tag, "_busy_after"}, bz, 0);
    if (!sel) chk({tag, "_ready_after"}, mr, 1);
  endtask

  initial begin
    logic [7:0] e_plain[$], e_escd[$], e_escc[$];
    int n;
    bit saw;
    e_plain = '{8'h02, 8'h88, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
                8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h64, 8'h9D, 8'h03};
    e_escd  = '{8'h02, 8'h88, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
                8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h1B, 8'h83, 8'hFA, 8'h03};
    e_escc  = '{8'h02, 8'h88, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
                8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFB, 8'h1B, 8'h82, 8'h03};
    set_msg(8'h64);

    @(negedge clk);
    chk("rst_msg_ready", mr, 0);
    chk("rst_tx_valid", tv, 0);
    chk("rst_tx_data", td, 0);
    chk("rst_busy", bz, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", mr, 1);
`ifdef SOUNDWEB_TX_FRAME_COUNT_EN
    chk("rst_frame_count", fc, 0);
`endif

    run_frame("plain", e_plain, 1'b0);
    set_msg(8'h03);
    run_frame("esc_data", e_escd, 1'b0);
    set_msg(8'hFB);
    run_frame("esc_csum", e_escc, 1'b0);
    set_msg(8'h64);
    run_frame("backpressure", e_plain, 1'b1);
`ifdef SOUNDWEB_TX_FRAME_COUNT_EN
    chk("count_4", fc, 4);
`endif

    send();
    n = 0;
    while (n < 5) begin
      if (tv) n++;
      @(negedge clk);
    end
    rst = 1'b1;
    chk("midrst_ready_low", mr, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx_valid", tv, 0);
    chk("midrst_busy", bz, 0);
`ifdef SOUNDWEB_TX_FRAME_COUNT_EN
    chk("midrst_count", fc, 0);
`endif
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tv) saw = 1'b1;
      @(negedge clk);
    end
    chk("midrst_quiet", saw, 0);
    run_frame("post_rst", e_plain, 1'b0);
`ifdef SOUNDWEB_TX_FRAME_COUNT_EN
    chk("post_rst_count", fc, 1);
`endif

    sel = 1'b1;
    @(negedge clk);
    run_frame("gap_f1", e_plain, 1'b0);
    n = 0;
    while (!mr && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("gap_ready_low_cycles", n, 4);
    run_frame("gap_f2", e_plain, 1'b0);
`ifdef SOUNDWEB_TX_FRAME_COUNT_EN
    chk("gap_count_2", fc, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
